// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing / test-pattern block.
package vga_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    PAT_BLACK = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_GRID  = 2'd2,
    PAT_GRAD  = 2'd3
  } pattern_e;

  localparam rgb_t WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam rgb_t BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern colour for one pixel; blanking is applied by the caller.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int HDISP = 640,
  parameter int CW_H  = 10
) (
  input  logic [CW_H-1:0] x,
  input  logic [7:0]      y,
  input  pattern_e        pattern,
  output rgb_t            rgb
);
  localparam int BAR_W = HDISP / 8;

  logic [CW_H-1:0] bar;
  logic [2:0]      k;

  always_comb begin
    bar = x / CW_H'(BAR_W);
    if (bar > CW_H'(7)) bar = CW_H'(7);
    k   = bar[2:0];
    rgb = BLACK;
    case (pattern)
      PAT_BARS: rgb = '{r: {8{k[2]}}, g: {8{k[1]}}, b: {8{k[0]}}};
      PAT_GRID: if (4'(x) == 4'd0 || y[3:0] == 4'd0) rgb = WHITE;
      PAT_GRAD: rgb = '{r: 8'(x), g: y, b: 8'h00};
      default:  rgb = BLACK;
    endcase
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, sync/blank decode and registered,
// mutually aligned pixel outputs (one cycle behind the counters).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HDISP  = 640,
  parameter int VDISP  = 480,
  parameter int HFP    = 16,
  parameter int HPULSE = 96,
  parameter int HBP    = 48,
  parameter int VFP    = 11,
  parameter int VPULSE = 2,
  parameter int VBP    = 31,
  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP,
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP,
  localparam int CW_H   = $clog2(HTOTAL),
  localparam int CW_V   = $clog2(VTOTAL)
) (
  input  logic            fpga_CLK_AUX,
  input  logic            fpga_NRST,
  input  logic            vga_en,
  input  logic [1:0]      vga_pattern,
  output logic            vga_hs,
  output logic            vga_vs,
  output logic            vga_blank_n,
  output logic [CW_H-1:0] vga_x,
  output logic [CW_V-1:0] vga_y,
  output logic [7:0]      vga_r,
  output logic [7:0]      vga_g,
  output logic [7:0]      vga_b,
  output logic            vga_sof
);
  localparam int HS_START = HDISP + HFP;
  localparam int HS_END   = HS_START + HPULSE;
  localparam int VS_START = VDISP + VFP;
  localparam int VS_END   = VS_START + VPULSE;

  logic [CW_H-1:0] hcnt_q, hcnt_d, x_q, x_d;
  logic [CW_V-1:0] vcnt_q, vcnt_d, y_q, y_d;
  pattern_e        pat_q, pat_d, pat_cur;
  logic            hs_q, hs_d, vs_q, vs_d;
  logic            blank_n_q, blank_n_d, sof_q, sof_d;
  rgb_t            rgb_q, rgb_d, pix;
  logic            at_origin, active;

  // The frame's first pixel already uses the freshly sampled pattern.
  always_comb begin
    at_origin = (hcnt_q == '0) && (vcnt_q == '0);
    pat_cur   = at_origin ? pattern_e'(vga_pattern) : pat_q;
    pat_d     = pat_cur;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    if (!vga_en) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (hcnt_q == CW_H'(HTOTAL - 1)) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == CW_V'(VTOTAL - 1)) ? '0 : vcnt_q + 1'b1;
    end else begin
      hcnt_d = hcnt_q + 1'b1;
    end
  end

  vga_pattern_gen #(
    .HDISP (HDISP),
    .CW_H  (CW_H)
  ) u_pattern (
    .x       (hcnt_q),
    .y       (8'(vcnt_q)),
    .pattern (pat_cur),
    .rgb     (pix)
  );

  always_comb begin
    active    = (hcnt_q < CW_H'(HDISP)) && (vcnt_q < CW_V'(VDISP));
    hs_d      = !((hcnt_q >= CW_H'(HS_START)) && (hcnt_q < CW_H'(HS_END)));
    vs_d      = !((vcnt_q >= CW_V'(VS_START)) && (vcnt_q < CW_V'(VS_END)));
    blank_n_d = active;
    x_d       = hcnt_q;
    y_d       = vcnt_q;
    rgb_d     = active ? pix : BLACK;
    sof_d     = at_origin;
    if (!vga_en) begin
      hs_d      = 1'b1;
      vs_d      = 1'b1;
      blank_n_d = 1'b0;
      x_d       = '0;
      y_d       = '0;
      rgb_d     = BLACK;
      sof_d     = 1'b0;
    end
  end

  always_ff @(posedge fpga_CLK_AUX or negedge fpga_NRST) begin
    if (!fpga_NRST) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      pat_q     <= PAT_BLACK;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      rgb_q     <= BLACK;
      sof_q     <= 1'b0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      pat_q     <= pat_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rgb_q     <= rgb_d;
      sof_q     <= sof_d;
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_x       = x_q;
  assign vga_y       = y_q;
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign vga_sof     = sof_q;

endmodule
